// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: internal prescaler tick, run/pause/step control,
// four selectable patterns and a two-digit BCD advance counter.
module led_seq_ctrl #(
  parameter int NUM_LEDS  = 18,
  parameter int DIV_WIDTH = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                pause,
  input  logic                step,
  input  logic                clear,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          state,
  output logic [7:0]          steps_bcd,
  output logic                tick
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  localparam logic [1:0] M_ROTL   = 2'd0;
  localparam logic [1:0] M_ROTR   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;

  state_t               state_q;
  logic [NUM_LEDS-1:0]  leds_q;
  logic [DIV_WIDTH-1:0] presc_q;
  logic                 dir_up_q;
  logic [1:0]           mode_q;
  logic [3:0]           tens_q;
  logic [3:0]           ones_q;
  logic                 start_prev_q;
  logic                 pause_prev_q;
  logic                 step_prev_q;

  logic                 start_ev;
  logic                 pause_ev;
  logic                 step_ev;
  logic                 presc_max;
  logic                 adv;
  logic [1:0]           eff_mode;
  logic [NUM_LEDS-1:0]  base_leds;
  logic                 base_dir;
  logic [NUM_LEDS-1:0]  adv_leds;
  logic                 adv_dir;
  logic [3:0]           tens_next;
  logic [3:0]           ones_next;

  function automatic logic [NUM_LEDS-1:0] init_pattern(input logic [1:0] m);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    case (m)
      M_ROTR:           p[NUM_LEDS-1] = 1'b1;
      M_ROTL, M_BOUNCE: p[0] = 1'b1;
      default:          p = '0;
    endcase
    return p;
  endfunction

  assign start_ev  = start & ~start_prev_q;
  assign pause_ev  = pause & ~pause_prev_q;
  assign step_ev   = step & ~step_prev_q;
  assign presc_max = &presc_q;

  // Advance qualification, honouring clear > start > pause > step > tick.
  always_comb begin
    adv = 1'b0;
    if (!clear) begin
      case (state_q)
        S_IDLE:   adv = step_ev & ~start_ev;
        S_RUN:    adv = presc_max & ~pause_ev;
        S_PAUSED: adv = step_ev & ~start_ev;
        default:  adv = 1'b0;
      endcase
    end
  end

  assign tick = adv;

  // A step out of IDLE advances from the live mode's initial pattern,
  // since that mode is the one being latched in the same cycle.
  always_comb begin
    eff_mode  = (state_q == S_IDLE) ? mode : mode_q;
    base_leds = (state_q == S_IDLE) ? init_pattern(mode) : leds_q;
    base_dir  = (state_q == S_IDLE) ? 1'b1 : dir_up_q;
    adv_dir   = base_dir;
    adv_leds  = base_leds;
    case (eff_mode)
      M_ROTL:   adv_leds = {base_leds[NUM_LEDS-2:0], base_leds[NUM_LEDS-1]};
      M_ROTR:   adv_leds = {base_leds[0], base_leds[NUM_LEDS-1:1]};
      M_BOUNCE: begin
        adv_leds = base_dir ? (base_leds << 1) : (base_leds >> 1);
        if (adv_leds[NUM_LEDS-1])
          adv_dir = 1'b0;
        else if (adv_leds[0])
          adv_dir = 1'b1;
      end
      default:  adv_leds = base_leds + NUM_LEDS'(1);
    endcase
  end

  always_comb begin
    tens_next = tens_q;
    ones_next = ones_q + 4'd1;
    if (ones_q == 4'd9) begin
      ones_next = 4'd0;
      tens_next = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      leds_q       <= '0;
      presc_q      <= '0;
      dir_up_q     <= 1'b1;
      mode_q       <= 2'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      step_prev_q  <= 1'b1;
    end else begin
      start_prev_q <= start;
      pause_prev_q <= pause;
      step_prev_q  <= step;

      if (clear) begin
        state_q  <= S_IDLE;
        presc_q  <= '0;
        tens_q   <= 4'd0;
        ones_q   <= 4'd0;
        leds_q   <= init_pattern(mode);
        dir_up_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            presc_q  <= '0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            leds_q   <= init_pattern(mode);
            dir_up_q <= 1'b1;
            if (start_ev) begin
              state_q <= S_RUN;
              mode_q  <= mode;
            end else if (step_ev) begin
              state_q <= S_PAUSED;
              mode_q  <= mode;
            end
          end
          S_RUN: begin
            // The prescaler keeps counting in the pause cycle, so the held
            // value is one past the value seen when pause was sampled.
            presc_q <= presc_q + DIV_WIDTH'(1);
            if (pause_ev)
              state_q <= S_PAUSED;
          end
          S_PAUSED: begin
            if (start_ev)
              state_q <= S_RUN;
          end
          default: state_q <= S_IDLE;
        endcase
      end

      if (adv) begin
        leds_q   <= adv_leds;
        dir_up_q <= adv_dir;
        tens_q   <= tens_next;
        ones_q   <= ones_next;
      end
    end
  end

  assign leds      = leds_q;
  assign state     = state_q;
  assign steps_bcd = {tens_q, ones_q};

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl (4 LEDs, tick every 4 clocks): directed scenarios
// then random control activity, all checked against a count-based model.
module tb_led_seq_ctrl;

  localparam int N   = 4;
  localparam int DW  = 2;
  localparam int PER = 1 << DW;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         pause;
  logic         step;
  logic         clear;
  logic [1:0]   mode;
  logic [N-1:0] leds;
  logic [1:0]   state;
  logic [7:0]   steps_bcd;
  logic         tick;

  always #5 clk = ~clk;

  led_seq_ctrl #(.NUM_LEDS(N), .DIV_WIDTH(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .pause    (pause),
    .step     (step),
    .clear    (clear),
    .mode     (mode),
    .leds     (leds),
    .state    (state),
    .steps_bcd(steps_bcd),
    .tick     (tick)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: pattern and BCD are derived from the number of advances made
  // since the block last left IDLE, plus the position within the period.
  int m_state;
  int m_cnt;
  int m_phase;
  int m_mode;
  int m_idle_mode;
  bit m_fresh;
  bit m_ps, m_pp, m_pst;
  bit m_adv;
  logic last_tick;

  function automatic logic [N-1:0] pat(input int md, input int c);
    int p;
    case (md)
      0:       return N'(1 << (c % N));
      1:       return N'((1 << (N - 1)) >> (c % N));
      2: begin
        p = c % (2 * (N - 1));
        return N'(1 << ((p <= N - 1) ? p : 2 * (N - 1) - p));
      end
      default: return N'(c % (1 << N));
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int c);
    int v;
    v = c % 100;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [N-1:0] exp_leds();
    if (m_state == 0)
      return m_fresh ? '0 : pat(m_idle_mode, 0);
    return pat(m_mode, m_cnt);
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_phase = 0; m_mode = 0; m_idle_mode = 0;
    m_fresh = 1'b1; m_ps = 1'b1; m_pp = 1'b1; m_pst = 1'b1; m_adv = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tick before the edge, outputs after it.
  task automatic cyc(input bit s, input bit p, input bit st, input bit cl, input logic [1:0] md);
    bit se, pe, ste;
    start = s; pause = p; step = st; clear = cl; mode = md;
    #1;
    se = s & ~m_ps; pe = p & ~m_pp; ste = st & ~m_pst;
    m_adv = 1'b0;
    if (cl) begin
      m_state = 0; m_cnt = 0; m_phase = 0;
    end else begin
      case (m_state)
        0: begin
          if (se) begin
            m_state = 1; m_mode = int'(md); m_cnt = 0; m_phase = 0;
          end else if (ste) begin
            m_state = 2; m_mode = int'(md); m_cnt = 1; m_adv = 1'b1;
          end
        end
        1: begin
          if (m_phase == PER - 1 && !pe) begin
            m_adv = 1'b1; m_cnt++;
          end
          m_phase = (m_phase + 1) % PER;
          if (pe) m_state = 2;
        end
        default: begin
          if (se) m_state = 1;
          else if (ste) begin
            m_adv = 1'b1; m_cnt++;
          end
        end
      endcase
    end
    m_idle_mode = int'(md);
    m_fresh = 1'b0;
    m_ps = s; m_pp = p; m_pst = st;
    last_tick = tick;
    check("tick", 32'(tick), 32'(m_adv));
    @(posedge clk);
    #1;
    check("leds", 32'(leds), 32'(exp_leds()));
    check("state", 32'(state), 32'(m_state));
    check("steps_bcd", 32'(steps_bcd), 32'(to_bcd(m_cnt)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0; clear = 1'b0; mode = 2'd0;
    model_reset();
    #2;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_bcd", 32'(steps_bcd), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    #10;
    reset_n = 1'b1;

    // Rotate-left from reset
    cyc(0, 0, 0, 0, 2'd0);
    check("a_init", 32'(leds), 32'h1);
    cyc(1, 0, 0, 0, 2'd0);
    repeat (16) cyc(0, 0, 0, 0, 2'd0);
    check("a_wrap_leds", 32'(leds), 32'h1);
    check("a_wrap_bcd", 32'(steps_bcd), 32'h04);

    // Bounce, 10 ticks
    cyc(0, 0, 0, 1, 2'd2);
    cyc(0, 0, 0, 0, 2'd2);
    cyc(1, 0, 0, 0, 2'd2);
    repeat (40) cyc(0, 0, 0, 0, 2'd2);
    check("b_leds", 32'(leds), 32'h4);
    check("b_bcd", 32'(steps_bcd), 32'h10);

    // Binary count with BCD wrap
    cyc(0, 0, 0, 1, 2'd3);
    cyc(1, 0, 0, 0, 2'd3);
    repeat (396) cyc(0, 0, 0, 0, 2'd3);
    check("c_bcd99", 32'(steps_bcd), 32'h99);
    check("c_leds99", 32'(leds), 32'h3);
    repeat (4) cyc(0, 0, 0, 0, 2'd3);
    check("c_bcd00", 32'(steps_bcd), 32'h00);
    check("c_leds100", 32'(leds), 32'h4);

    // Pause, step, resume latency
    cyc(0, 0, 0, 1, 2'd0);
    cyc(1, 0, 0, 0, 2'd0);
    repeat (8) cyc(0, 0, 0, 0, 2'd0);
    check("d_two_ticks", 32'(leds), 32'h4);
    cyc(0, 1, 0, 0, 2'd0);
    repeat (20) cyc(0, 1, 0, 0, 2'd0);
    check("d_hold_leds", 32'(leds), 32'h4);
    check("d_hold_state", 32'(state), 32'h2);
    cyc(0, 0, 0, 0, 2'd0);
    cyc(0, 0, 1, 0, 2'd0);
    check("d_step1", 32'(leds), 32'h8);
    cyc(0, 0, 0, 0, 2'd0);
    cyc(0, 0, 1, 0, 2'd0);
    check("d_step2", 32'(leds), 32'h1);
    check("d_step_bcd", 32'(steps_bcd), 32'h04);
    cyc(0, 0, 0, 0, 2'd0);
    cyc(1, 0, 0, 0, 2'd0);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      cyc(0, 0, 0, 0, 2'd0);
      if (last_tick === 1'b1) begin
        seen = 1'b1; lat = i;
      end
    end
    check("d_resume_lat", 32'(lat), 32'd3);

    // Priority and mode latching
    cyc(1, 0, 0, 1, 2'd0);
    check("e_clear_wins", 32'(state), 32'h0);
    cyc(0, 0, 0, 0, 2'd0);
    cyc(1, 0, 0, 0, 2'd0);
    repeat (3) cyc(0, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 0, 2'd0);
    check("e_pause_tick_leds", 32'(leds), 32'h1);
    check("e_pause_tick_bcd", 32'(steps_bcd), 32'h00);
    cyc(0, 0, 0, 0, 2'd3);
    cyc(1, 0, 0, 0, 2'd3);
    repeat (8) cyc(0, 0, 0, 0, 2'd3);
    check("e_latched_mode", 32'(leds), 32'h4);
    cyc(0, 0, 0, 1, 2'd3);
    check("e_after_clear", 32'(leds), 32'h0);

    // Asynchronous reset mid-run, start held through release
    cyc(0, 0, 0, 1, 2'd0);
    cyc(1, 0, 0, 0, 2'd0);
    repeat (8) cyc(0, 0, 0, 0, 2'd0);
    check("f_pre_leds", 32'(leds), 32'h4);
    #2;
    reset_n = 1'b0;
    start = 1'b1;
    #1;
    check("f_async_leds", 32'(leds), 32'h0);
    check("f_async_state", 32'(state), 32'h0);
    check("f_async_bcd", 32'(steps_bcd), 32'h0);
    check("f_async_tick", 32'(tick), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (3) cyc(1, 0, 0, 0, 2'd0);
    check("f_no_start_evt", 32'(state), 32'h0);

    // Random control activity
    cyc(0, 0, 0, 0, 2'd1);
    repeat (600) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0,
          2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
